// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Walks the shared mat_mul engine through the three layers of the inference
// MLP (input->W hidden, W->W hidden, W->1 output). One Q11 sample enters per
// inference. Between the hidden layers the engine result is passed through
// ReLU and rescaled by >>> FRAC. The scalar result of the last layer is
// rescaled (no ReLU) and held on the output until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid (and its data) until that edge, and
// ready never depends on valid.
//
// Ports
//   clk, reset     : clock; synchronous active-low reset
//   in_valid/ready : input sample handshake, in_data is a signed Q11 sample
//   out_valid/ready: result handshake, out_data is the signed Q11 result
//   mm_start       : one-cycle start pulse to the engine
//   mm_layer       : layer select (0, 1, 2) for the engine's weight ROMs
//   mm_vec         : operand vector, stable from start until done
//   mm_result      : engine result vector (bias already added)
//   mm_done        : one-cycle completion pulse from the engine
//   busy           : high in every state except IDLE
//   err_timeout    : sticky watchdog error, cleared when a sample is accepted
//
// Optional feature: define MLP_SEQ_WATCHDOG_EN to bound every WAIT state to
// TIMEOUT cycles. Without it the WAIT states wait forever and err_timeout is 0.
// -----------------------------------------------------------------------------
module mlp_layer_sequencer #(
  parameter int N       = 32,
  parameter int W       = 6,
  parameter int FRAC    = 11,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [15:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                mm_start,
  output logic [1:0]          mm_layer,
  output logic signed [N-1:0] mm_vec [W],
  input  logic signed [N-1:0] mm_result [W],
  input  logic                mm_done,
  output logic                busy,
  output logic                err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_L0_ISSUE, S_L0_WAIT, S_L1_ISSUE,
    S_L1_WAIT, S_L2_ISSUE, S_L2_WAIT, S_OUT_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic signed [N-1:0] out_data_q, out_data_d;
  logic                mm_start_q, mm_start_d;
  logic [1:0]          mm_layer_q, mm_layer_d;
  logic signed [N-1:0] mm_vec_q [W];
  logic signed [N-1:0] mm_vec_d [W];
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                accept;
  logic                wd_expire;

  assign in_ready = (state_q == S_IDLE) && reset;
  assign accept   = in_valid && in_ready;

`ifdef MLP_SEQ_WATCHDOG_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          in_wait;

  // WAIT states are only entered from ISSUE, so the count is 0 on the first
  // WAIT cycle and reaches TIMEOUT-1 on the TIMEOUT-th cycle without done.
  assign in_wait   = (state_q == S_L0_WAIT) || (state_q == S_L1_WAIT) ||
                     (state_q == S_L2_WAIT);
  assign wd_cnt_d  = in_wait ? (wd_cnt_q + CW'(1)) : '0;
  assign wd_expire = in_wait && (wd_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    mm_layer_d = mm_layer_q;
    mm_vec_d   = mm_vec_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mm_vec_d[0] = N'(in_data);
          for (int i = 1; i < W; i++) mm_vec_d[i] = '0;
          mm_layer_d = 2'd0;
          err_d      = 1'b0;
          state_d    = S_L0_ISSUE;
        end
      end
      S_L0_ISSUE: state_d = S_L0_WAIT;
      S_L1_ISSUE: state_d = S_L1_WAIT;
      S_L2_ISSUE: state_d = S_L2_WAIT;
      S_L0_WAIT, S_L1_WAIT: begin
        // done has priority over a watchdog expiry in the same cycle
        if (mm_done) begin
          for (int i = 0; i < W; i++) begin
            if (mm_result[i][N-1]) mm_vec_d[i] = '0;
            else                   mm_vec_d[i] = mm_result[i] >>> FRAC;
          end
          mm_layer_d = (state_q == S_L0_WAIT) ? 2'd1 : 2'd2;
          state_d    = (state_q == S_L0_WAIT) ? S_L1_ISSUE : S_L2_ISSUE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_L2_WAIT: begin
        if (mm_done) begin
          out_data_d = mm_result[0] >>> FRAC;
          state_d    = S_OUT_HOLD;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT_HOLD: if (out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    mm_start_d  = (state_d == S_L0_ISSUE) || (state_d == S_L1_ISSUE) ||
                  (state_d == S_L2_ISSUE);
    out_valid_d = (state_d == S_OUT_HOLD);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mm_start_q  <= 1'b0;
      mm_layer_q  <= 2'd0;
      for (int i = 0; i < W; i++) mm_vec_q[i] <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mm_start_q  <= mm_start_d;
      mm_layer_q  <= mm_layer_d;
      for (int i = 0; i < W; i++) mm_vec_q[i] <= mm_vec_d[i];
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign mm_start    = mm_start_q;
  assign mm_layer    = mm_layer_q;
  assign mm_vec      = mm_vec_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_layer_sequencer
//
// Bench for mlp_layer_sequencer. The bench plays the mat_mul engine itself,
// cycle by cycle, so every layer's latency and result are under its control.
// A table of hand-derived vectors is run first, then hand-written corner
// sequences, then randomized inferences whose expectations come from a
// floor-division model of the Q11 ReLU/rescale rules.
// -----------------------------------------------------------------------------
module tb_mlp_layer_sequencer;
  localparam int N       = 32;
  localparam int W       = 6;
  localparam int FRAC    = 11;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_data;
  logic                mm_start;
  logic [1:0]          mm_layer;
  logic signed [N-1:0] mm_vec [W];
  logic signed [N-1:0] mm_result [W];
  logic                mm_done;
  logic                busy;
  logic                err_timeout;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.N(N), .W(W), .FRAC(FRAC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mm_start(mm_start), .mm_layer(mm_layer), .mm_vec(mm_vec),
    .mm_result(mm_result), .mm_done(mm_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- types and scoreboard ----------------
  typedef logic [W-1:0][N-1:0] vec_t;
  typedef struct packed {
    logic [15:0]  din;
    vec_t         r0;
    vec_t         r1;
    logic [N-1:0] r2;
    logic [7:0]   lat;
    vec_t         exp_v1;
    vec_t         exp_v2;
    logic [N-1:0] exp_out;
  } case_t;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];   // expected results, oldest first

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Q11 rescale as true floor division by 2^FRAC.
  function automatic logic signed [N-1:0] floor_q(input logic signed [N-1:0] r);
    longint v, d, q;
    v = r;
    d = longint'(1) << FRAC;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return N'(q);
  endfunction

  function automatic vec_t relu_vec(input vec_t r);
    vec_t o;
    for (int i = 0; i < W; i++)
      o[i] = ($signed(r[i]) < 0) ? '0 : floor_q($signed(r[i]));
    return o;
  endfunction

  function automatic vec_t fill(input int v);
    vec_t o;
    for (int i = 0; i < W; i++) o[i] = v;
    return o;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int d, input int e, input int f);
    vec_t o;
    o[0] = a; o[1] = b; o[2] = c; o[3] = d; o[4] = e; o[5] = f;
    return o;
  endfunction

  function automatic vec_t first_vec(input logic [15:0] din);
    vec_t o = '0;
    o[0] = N'($signed(din));
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_result();
    for (int i = 0; i < W; i++) mm_result[i] = $urandom;
  endtask

  task automatic accept(input logic [15:0] din);
    int n = 0;
    in_valid = 1'b1;
    in_data  = din;
    while (!in_ready && n < 50) begin step(); n++; end
    check("in_ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // Called in the cycle the ISSUE state is expected; returns in the cycle
  // after the engine's done pulse.
  task automatic do_layer(input int k, input int lat, input vec_t res,
                          input vec_t exp_vec, input bit spur);
    bit same;
    check($sformatf("l%0d_mm_start", k), mm_start, 1);
    check($sformatf("l%0d_mm_layer", k), mm_layer, k);
    for (int i = 0; i < W; i++)
      check($sformatf("l%0d_mm_vec%0d", k, i), mm_vec[i], $signed(exp_vec[i]));
    if (spur) begin
      mm_done = 1'b1;
      scramble_result();
    end
    step();
    mm_done = 1'b0;
    check($sformatf("l%0d_start_single", k), mm_start, 0);
    for (int j = 1; j < lat; j++) step();
    same = (mm_layer == 2'(k));
    for (int i = 0; i < W; i++) if (mm_vec[i] !== exp_vec[i]) same = 1'b0;
    check($sformatf("l%0d_operands_stable", k), same, 1);
    if (k == 2) check("out_valid_not_early", out_valid, 0);
    for (int i = 0; i < W; i++) mm_result[i] = res[i];
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    scramble_result();
  endtask

  task automatic run_case(input case_t c, input int bp, input bit spur);
    vec_t r2v;
    bit   held;
    logic [N-1:0] exp_out;
    exp_q.push_back(c.exp_out);
    r2v = fill(0);
    r2v[0] = c.r2;
    accept(c.din);
    do_layer(0, int'(c.lat), c.r0, first_vec(c.din), 1'b0);
    do_layer(1, int'(c.lat), c.r1, c.exp_v1, spur);
    do_layer(2, int'(c.lat), r2v, c.exp_v2, 1'b0);
    exp_out = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    check("out_data", out_data, $signed(exp_out));
    check("busy_in_hold", busy, 1);
    check("in_ready_in_hold", in_ready, 0);
    check("err_timeout_clear", err_timeout, 0);
    held = 1'b1;
    for (int j = 0; j < bp; j++) begin
      step();
      if (out_data !== exp_out || out_valid !== 1'b1 || in_ready !== 1'b0)
        held = 1'b0;
    end
    check("backpressure_hold", held, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("in_ready_after_out", in_ready, 1);
    check("out_valid_after_out", out_valid, 0);
    check("busy_after_out", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    bit z = 1'b1;
    for (int i = 0; i < W; i++) if (mm_vec[i] !== '0) z = 1'b0;
    check({tag, "_mm_vec"}, z, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_mm_start"}, mm_start, 0);
    check({tag, "_mm_layer"}, mm_layer, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // ---------------- test ----------------
  case_t tbl[4];
  case_t c;

  initial begin
    // table of hand-derived vectors
    tbl[0].din = 16'sd2048;  tbl[0].lat = 8'd1;
    tbl[0].r0 = fill(4096);  tbl[0].r1 = fill(6144);  tbl[0].r2 = -32'sd2048;
    tbl[0].exp_v1 = fill(2); tbl[0].exp_v2 = fill(3); tbl[0].exp_out = -32'sd1;

    tbl[1].din = -16'sd300;  tbl[1].lat = 8'd2;
    tbl[1].r0 = mk(-4096, 4096, 0, 1, 2047, 2048);
    tbl[1].r1 = fill(-5);    tbl[1].r2 = 32'sd5000;
    tbl[1].exp_v1 = mk(0, 2, 0, 0, 0, 1); tbl[1].exp_v2 = fill(0);
    tbl[1].exp_out = 32'sd2;

    tbl[2].din = 16'sd32767; tbl[2].lat = 8'd3;
    tbl[2].r0 = fill(0);
    tbl[2].r1 = mk(14341, -1, 4095, 4096, -100000, 1048576);
    tbl[2].r2 = -32'sd1;
    tbl[2].exp_v1 = fill(0); tbl[2].exp_v2 = mk(7, 0, 1, 2, 0, 512);
    tbl[2].exp_out = -32'sd1;

    tbl[3].din = 16'h8000;   tbl[3].lat = 8'd4;
    tbl[3].r0 = fill(32'h7FFF_FFFF); tbl[3].r1 = fill(32'h8000_0000);
    tbl[3].r2 = -32'sd4097;
    tbl[3].exp_v1 = fill(1048575); tbl[3].exp_v2 = fill(0);
    tbl[3].exp_out = -32'sd3;

    // reset
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mm_done = 1'b0;
    for (int i = 0; i < W; i++) mm_result[i] = '0;
    repeat (3) step();
    check_all_zero("reset");
    check("in_ready_in_reset", in_ready, 0);
    reset = 1'b1;
    #1;
    check("in_ready_after_reset", in_ready, 1);
    step();

    // table vectors; entry 1 gets a spurious done in L1_ISSUE and
    // the longer entries get output backpressure (10 cycles on the last)
    for (int t = 0; t < 4; t++)
      run_case(tbl[t], (t == 3) ? 10 : t, t == 1);

    // spurious done while IDLE
    mm_done = 1'b1;
    scramble_result();
    step();
    mm_done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_mm_start", mm_start, 0);
    check("idle_done_in_ready", in_ready, 1);
    step();
    check("idle_done_mm_start2", mm_start, 0);

    // reset for one cycle during L1_WAIT, then a late done from the engine
    accept(16'sd1000);
    do_layer(0, 2, fill(4096), first_vec(16'sd1000), 1'b0);
    step();
    check("midrst_busy_in_l1_wait", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_in_ready_in_reset", in_ready, 0);
    step();
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    check("midrst_in_ready", in_ready, 1);
    mm_done = 1'b1;
    for (int i = 0; i < W; i++) mm_result[i] = 32'sd4096;
    step();
    mm_done = 1'b0;
    check_all_zero("late_done");
    check("late_done_in_ready", in_ready, 1);
    step();
    check("late_done_no_start", mm_start, 0);

    // randomized inferences against the model
    for (int n = 0; n < 24; n++) begin
      c.din = 16'($urandom);
      for (int i = 0; i < W; i++) begin
        c.r0[i] = ($urandom_range(0, 3) == 0) ? $urandom
                                             : ($urandom_range(0, 40000) - 20000);
        c.r1[i] = ($urandom_range(0, 3) == 0) ? $urandom
                                             : ($urandom_range(0, 40000) - 20000);
      end
      c.r2      = ($urandom_range(0, 1) == 0) ? $urandom
                                             : ($urandom_range(0, 40000) - 20000);
      c.lat     = 8'($urandom_range(1, 5));
      c.exp_v1  = relu_vec(c.r0);
      c.exp_v2  = relu_vec(c.r1);
      c.exp_out = floor_q($signed(c.r2));
      run_case(c, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

`ifdef MLP_SEQ_WATCHDOG_EN
    // engine never answers: give up after TIMEOUT cycles in L0_WAIT
    accept(16'sd5);
    for (int j = 0; j < TIMEOUT; j++) step();
    check("wd_busy_last_wait", busy, 1);
    check("wd_err_not_yet", err_timeout, 0);
    step();
    check("wd_busy_after", busy, 0);
    check("wd_err_set", err_timeout, 1);
    check("wd_out_valid", out_valid, 0);
    check("wd_in_ready", in_ready, 1);
    step();
    check("wd_err_sticky", err_timeout, 1);
    accept(16'sd7);
    check("wd_err_cleared", err_timeout, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Sequences the shared `mat_mul` engine through the three layers of the inference MLP (input→W hidden, W→W hidden, W→1 output) using an explicit start/done handshake. Accepts one Q11 sample per inference on a valid/ready input and presents the scalar result on a valid/ready output. Between layers it applies ReLU and Q11 rescaling, and latches the activation vector that feeds the next pass. It sits between the sample source and the `mat_mul` instance, which keeps ownership of the weight/bias ROMs selected by `mm_layer`.

## Interface
- `N`, 32: datapath width of vector elements and results.
- `W`, 6: vector length (hidden-layer width).
- `FRAC`, 11: fractional bits; every result is arithmetically shifted right by `FRAC`.
- `TIMEOUT`, 255: maximum wait cycles per layer (watchdog only).

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sequencer can accept a sample.
- `in_data` in 16 signed: Q11 input sample.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out N signed: Q11 inference result.
- `mm_start` out 1: one-cycle start pulse to the engine.
- `mm_layer` out 2: layer select to the engine (0, 1, 2).
- `mm_vec` out [W][N] signed: operand vector to the engine.
- `mm_result` in [W][N] signed: engine result (bias included).
- `mm_done` in 1: one-cycle completion pulse from the engine.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky watchdog error flag.

## Operation
- States: IDLE, L0_ISSUE, L0_WAIT, L1_ISSUE, L1_WAIT, L2_ISSUE, L2_WAIT, OUT_HOLD.
- `in_ready` = (state==IDLE) && `reset`. A handshake in IDLE loads `mm_vec[0]` = sign-extended `in_data`; elements 1..W-1 load 0. Next state is L0_ISSUE.
- Lk_ISSUE: `mm_start`=1 and `mm_layer`=k for exactly one cycle, then go to Lk_WAIT.
- Lk_WAIT: on `mm_done`, process `mm_result` and advance.
  - After L0 and L1: latch `mm_vec[i]` = (r<0) ? 0 : (r >>> FRAC) for all i, then go to L(k+1)_ISSUE.
  - After L2: latch `out_data` = `mm_result[0]` >>> FRAC (no ReLU), then go to OUT_HOLD.
- OUT_HOLD: `out_valid`=1. `out_data` is held stable until `out_ready`. Handshake → IDLE.
- `mm_vec` and `mm_layer` stay stable from the ISSUE cycle through the end of the matching WAIT.
- `mm_done` is ignored in IDLE, any ISSUE state, and OUT_HOLD.
- Accepting a new sample clears `err_timeout`.

## Timing
- Reset (`reset`=0): state=IDLE. `out_valid`, `out_data`, `mm_start`, `mm_layer`, `mm_vec`, `busy`, `err_timeout` all reset to 0. `in_ready`=0 while reset is asserted.
- Engine latency L is the number of cycles from the `mm_start` cycle to the `mm_done` cycle (L≥1).
- Latency: accept at cycle 0 → `out_valid` at cycle 3L+4. One throughput slot per inference; no overlap.
- `in_ready` rises the cycle after the output handshake (IDLE is re-entered).
- Reset mid-operation: the in-flight inference is discarded and `mm_start` is 0 from the next cycle. A later `mm_done` from the engine is ignored because the state is IDLE.
- `mm_done` coincident with the watchdog expiry: done wins; no error.
- Arithmetic: `>>>` is arithmetic and rounds toward −∞. No saturation; results wrap to N bits.

## Configuration
- `MLP_SEQ_WATCHDOG_EN` defined:
  - A per-WAIT counter resets to 0 on entry to each WAIT state.
  - If the counter reaches `TIMEOUT` without `mm_done`, the next state is IDLE, `err_timeout` is set (sticky), and `out_valid` stays 0.
- Undefined: no counter, WAIT states wait indefinitely, and `err_timeout` is tied 0.

## Test plan
- Stub with L=1; layer results: L0 all 4096, L1 all 6144, L2 [0]=-2048. Drive `in_data`=2048 → `mm_vec` after L0 = all 2; after L1 = all 3; `out_data`=-1; `out_valid` at cycle 7 after accept.
- L0 result [-4096, 4096, 0, 1, 2047, 2048] → latched `mm_vec` = [0, 2, 0, 0, 0, 1].
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stable and `in_ready`=0 throughout; `out_ready`=1 → `in_ready`=1 the next cycle.
- Spurious `mm_done` pulses in IDLE and in L1_ISSUE → no state change and no extra `mm_start`.
- `reset`=0 for one cycle during L1_WAIT, then the engine asserts `mm_done` → state IDLE, all outputs 0, `in_ready`=1 after reset is released.
- With `MLP_SEQ_WATCHDOG_EN` and `TIMEOUT`=16, stub never done → IDLE and `err_timeout`=1 after 16 cycles in L0_WAIT. The next accepted sample clears `err_timeout`.
